// File: rtl/sp_sram_pkg.sv
// Shared constants and helpers for the sp_sram storage macro.
package sp_sram_pkg;

  localparam int BW_DATA_DEF = 32;
  localparam int BW_ADDR_DEF = 5;

  function automatic int depth_of(input int bw_addr);
    return 1 << bw_addr;
  endfunction

endpackage

// File: rtl/sp_sram_array.sv
// Raw storage: one write port and a registered read port, no reset.
// Kept reset-free so it can be replaced by a foundry SRAM macro.
module sp_sram_array
  import sp_sram_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_DEF,
  parameter int BW_ADDR = BW_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [BW_ADDR-1:0] i_addr,
  input  logic [BW_DATA-1:0] i_wdata,
  output logic [BW_DATA-1:0] o_rdata
);

  localparam int DEPTH = depth_of(BW_ADDR);

  logic [BW_DATA-1:0] mem_q [DEPTH];
  logic [BW_DATA-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_addr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/sp_sram.sv
// Single-port synchronous SRAM: 1-cycle read latency, per-word valid bits,
// synchronous reset that invalidates contents, combinational output gating.
module sp_sram
  import sp_sram_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_DEF,
  parameter int BW_ADDR = BW_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BW_DATA-1:0] i_data,
  input  logic [BW_ADDR-1:0] i_addr,
  input  logic               i_cen,
  input  logic               i_wen,
  input  logic               i_oen,
  output logic [BW_DATA-1:0] o_data
);

  localparam int DEPTH = depth_of(BW_ADDR);

  logic               wr_en;
  logic               rd_en;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               hit_q, hit_d;
  logic [BW_DATA-1:0] arr_rdata;

  // Reset outranks any access in the same cycle, so it gates both strobes.
  assign wr_en = i_cen &  i_wen & ~i_rst;
  assign rd_en = i_cen & ~i_wen & ~i_rst;

  sp_sram_array #(
    .BW_DATA (BW_DATA),
    .BW_ADDR (BW_ADDR)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_re    (rd_en),
    .i_addr  (i_addr),
    .i_wdata (i_data),
    .o_rdata (arr_rdata)
  );

  always_comb begin
    valid_d = valid_q;
    hit_d   = hit_q;
    if (wr_en) valid_d[i_addr] = 1'b1;
    if (rd_en) hit_d = valid_q[i_addr];
  end

  // hit_q marks whether the array's read register holds data from a valid
  // word; clearing it is equivalent to clearing the read register itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
    end
  end

  assign o_data = (i_oen && hit_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_sp_sram.sv
// Self-checking bench for sp_sram: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_sp_sram;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [4:0]  addr;
  logic        cen;
  logic        wen;
  logic        oen;
  logic [31:0] o_data;

  int vec_cnt;
  int err_cnt;

  logic [31:0] m_mem [32];
  bit          m_val [32];
  logic [31:0] m_rd;

  sp_sram dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data),
    .i_addr (addr),
    .i_cen  (cen),
    .i_wen  (wen),
    .i_oen  (oen),
    .o_data (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // then compare o_data shortly after.
  task automatic cyc(input bit r, input bit c, input bit w, input bit oe,
                     input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; cen = c; wen = w; oen = oe; addr = a; data = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_val[i] = 1'b0;
      m_rd = '0;
    end else if (c) begin
      if (w) begin
        m_mem[a] = d;
        m_val[a] = 1'b1;
      end else begin
        m_rd = m_val[a] ? m_mem[a] : 32'h0;
      end
    end
    #1;
    check_eq("model", o_data, oe ? m_rd : 32'h0);
  endtask

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;
    vec_cnt = 0;
    err_cnt = 0;
    m_rd = '0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    rst = 1'b1; cen = 1'b0; wen = 1'b0; oen = 1'b0; addr = '0; data = '0;

    // reset state, observed with output enabled
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 0, 32'hFFFF_FFFF);
    check_eq("reset_out", o_data, 32'h0);

    // fill and readback
    for (int i = 0; i < 32; i++) cyc(0, 1, 1, 1, 5'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 0, 1, 5'(i), 32'h0);
      check_eq("fill_rd", o_data, 32'(i));
    end

    // unwritten read after reset, then written
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 7, 0);
    check_eq("unwritten_rd", o_data, 32'h0);
    cyc(0, 1, 1, 1, 7, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 1, 7, 0);
    check_eq("written_rd", o_data, 32'hDEAD_BEEF);

    // chip disable ignores write attempts and holds output
    cyc(0, 1, 1, 1, 3, 32'h1234_5678);
    cyc(0, 1, 0, 1, 3, 0);
    cyc(0, 0, 1, 1, 3, 32'hFFFF_FFFF);
    check_eq("cen0_hold", o_data, 32'h1234_5678);
    cyc(0, 0, 1, 1, 3, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 1, 3, 0);
    check_eq("cen0_rd", o_data, 32'h1234_5678);

    // output enable gating, combinational after the register
    cyc(0, 1, 1, 1, 5, 32'hA5A5_A5A5);
    cyc(0, 1, 0, 0, 5, 0);
    check_eq("oen0", o_data, 32'h0);
    @(negedge clk);
    cen = 1'b0; oen = 1'b1;
    #1;
    check_eq("oen_raise", o_data, 32'hA5A5_A5A5);
    cyc(0, 0, 0, 1, 0, 0);

    // reset mid-operation drops the concurrent write
    cyc(0, 1, 1, 1, 10, 32'h1);
    cyc(1, 1, 1, 1, 11, 32'h2);
    check_eq("rst_mid_out", o_data, 32'h0);
    cyc(0, 1, 0, 1, 10, 0);
    check_eq("rst_rd10", o_data, 32'h0);
    cyc(0, 1, 0, 1, 11, 0);
    check_eq("rst_rd11", o_data, 32'h0);

    // write/read alternation
    for (int k = 0; k < 16; k++) begin
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      cyc(0, 1, 1, 1, ra, rd);
      cyc(0, 1, 0, 1, ra, ~rd);
      check_eq("alt_rd", o_data, rd);
    end

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 31)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
